bsg_dmi_axil_master: RTL

- DMI-to-AXI4-Lite initiator. It accepts RISC-V debug DMI requests from a DTM, such as a JTAG TAP or a host mailbox.
- It issues one AXI4-Lite master transaction per request into the debug bridge slave port, which decodes byte addresses below 32'h130000 as DMI. It returns a DMI response.
- It sits in the host/debug-transport domain and drives the debug bridge `s_axil_*` port.
- Strictly one transaction outstanding.

---
 rtl/bsg_dmi_axil_master.sv | 251 +++++++++++++++++++++++++
 1 files changed

// File: rtl/bsg_dmi_axil_master.sv
// rtl/bsg_dmi_axil_master.sv - DMI request/response to AXI4-Lite master bridge, one transaction outstanding
module bsg_dmi_axil_master #(
    parameter int axil_addr_width_p = 32,
    parameter int axil_data_width_p = 32,
    parameter int dmi_addr_width_p  = 7,
    parameter logic [axil_addr_width_p-1:0] base_addr_p = '0,
    parameter int timeout_p = 1024
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,

    input  logic                           dmi_req_v_i,
    output logic                           dmi_req_ready_o,
    input  logic [dmi_addr_width_p-1:0]    dmi_req_addr_i,
    input  logic [1:0]                     dmi_req_op_i,
    input  logic [31:0]                    dmi_req_data_i,
    output logic                           dmi_resp_v_o,
    input  logic                           dmi_resp_ready_i,
    output logic [31:0]                    dmi_resp_data_o,
    output logic [1:0]                     dmi_resp_resp_o,

    output logic [axil_addr_width_p-1:0]   m_axil_awaddr_o,
    output logic [2:0]                     m_axil_awprot_o,
    output logic                           m_axil_awvalid_o,
    input  logic                           m_axil_awready_i,
    output logic [axil_data_width_p-1:0]   m_axil_wdata_o,
    output logic [axil_data_width_p/8-1:0] m_axil_wstrb_o,
    output logic                           m_axil_wvalid_o,
    input  logic                           m_axil_wready_i,
    input  logic [1:0]                     m_axil_bresp_i,
    input  logic                           m_axil_bvalid_i,
    output logic                           m_axil_bready_o,
    output logic [axil_addr_width_p-1:0]   m_axil_araddr_o,
    output logic [2:0]                     m_axil_arprot_o,
    output logic                           m_axil_arvalid_o,
    input  logic                           m_axil_arready_i,
    input  logic [axil_data_width_p-1:0]   m_axil_rdata_i,
    input  logic [1:0]                     m_axil_rresp_i,
    input  logic                           m_axil_rvalid_i,
    output logic                           m_axil_rready_o
);

    localparam logic [1:0] op_read_lp    = 2'd1;
    localparam logic [1:0] op_write_lp   = 2'd2;
    localparam logic [1:0] dmi_ok_lp     = 2'd0;
    localparam logic [1:0] dmi_failed_lp = 2'd2;
    localparam logic [1:0] axi_okay_lp   = 2'd0;

    localparam logic [2:0] e_ready  = 3'd0;
    localparam logic [2:0] e_write  = 3'd1;
    localparam logic [2:0] e_read   = 3'd2;
    localparam logic [2:0] e_wait_b = 3'd3;
    localparam logic [2:0] e_wait_r = 3'd4;
    localparam logic [2:0] e_resp   = 3'd5;
    localparam logic [2:0] e_drain  = 3'd6;

    localparam int timer_width_lp = $clog2(timeout_p) + 1;
    localparam logic [timer_width_lp-1:0] timer_last_lp = timer_width_lp'(timeout_p - 1);

    logic [2:0]                   state_r, state_n;
    logic                         req_ready_r;
    logic [axil_addr_width_p-1:0] addr_r, req_axil_addr;
    logic [axil_data_width_p-1:0] wdata_r;
    logic                         aw_v_r, w_v_r, ar_v_r;
    logic                         drain_b_r, drain_r_r;
    logic [timer_width_lp-1:0]    timer_r;
    logic [31:0]                  resp_data_r, resp_data_n;
    logic [1:0]                   resp_code_r, resp_code_n;

    logic accept, in_timed, timed_out, load_resp;
    logic set_drain_b, set_drain_r;
    logic aw_left, w_left, ar_left, drain_left;

    assign accept    = dmi_req_v_i & req_ready_r;
    assign in_timed  = (state_r == e_write) | (state_r == e_read)
                     | (state_r == e_wait_b) | (state_r == e_wait_r);
    assign timed_out = (timer_r == timer_last_lp);

    assign req_axil_addr = base_addr_p + (axil_addr_width_p'(dmi_req_addr_i) << 2);

    // Work still owed to the slave after a timed-out request, as of the end of this cycle
    assign aw_left    = aw_v_r & ~m_axil_awready_i;
    assign w_left     = w_v_r  & ~m_axil_wready_i;
    assign ar_left    = ar_v_r & ~m_axil_arready_i;
    assign drain_left = aw_left | w_left | ar_left
                      | (drain_b_r & ~m_axil_bvalid_i)
                      | (drain_r_r & ~m_axil_rvalid_i);

    always_comb begin
        state_n     = state_r;
        load_resp   = 1'b0;
        resp_code_n = dmi_ok_lp;
        resp_data_n = '0;
        set_drain_b = 1'b0;
        set_drain_r = 1'b0;
        case (state_r)
            e_ready: begin
                if (accept) begin
                    case (dmi_req_op_i)
                        op_write_lp: state_n = e_write;
                        op_read_lp:  state_n = e_read;
                        default: begin
                            state_n   = e_resp;
                            load_resp = 1'b1;
                        end
                    endcase
                end
            end
            e_write: begin
                if (!aw_left && !w_left) begin
                    state_n = e_wait_b;
                end else if (timed_out) begin
                    state_n     = e_resp;
                    load_resp   = 1'b1;
                    resp_code_n = dmi_failed_lp;
                    set_drain_b = 1'b1;
                end
            end
            e_read: begin
                if (m_axil_arready_i) begin
                    state_n = e_wait_r;
                end else if (timed_out) begin
                    state_n     = e_resp;
                    load_resp   = 1'b1;
                    resp_code_n = dmi_failed_lp;
                    set_drain_r = 1'b1;
                end
            end
            e_wait_b: begin
                if (m_axil_bvalid_i) begin
                    state_n     = e_resp;
                    load_resp   = 1'b1;
                    resp_code_n = (m_axil_bresp_i == axi_okay_lp) ? dmi_ok_lp : dmi_failed_lp;
                end else if (timed_out) begin
                    state_n     = e_resp;
                    load_resp   = 1'b1;
                    resp_code_n = dmi_failed_lp;
                    set_drain_b = 1'b1;
                end
            end
            e_wait_r: begin
                if (m_axil_rvalid_i) begin
                    state_n   = e_resp;
                    load_resp = 1'b1;
                    if (m_axil_rresp_i == axi_okay_lp) begin
                        resp_data_n = m_axil_rdata_i[31:0];
                    end else begin
                        resp_code_n = dmi_failed_lp;
                    end
                end else if (timed_out) begin
                    state_n     = e_resp;
                    load_resp   = 1'b1;
                    resp_code_n = dmi_failed_lp;
                    set_drain_r = 1'b1;
                end
            end
            e_resp: begin
                if (dmi_resp_ready_i) begin
                    state_n = drain_left ? e_drain : e_ready;
                end
            end
            e_drain: begin
                if (!drain_left) begin
                    state_n = e_ready;
                end
            end
            default: state_n = e_ready;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r     <= e_ready;
            req_ready_r <= 1'b0;
            addr_r      <= '0;
            wdata_r     <= '0;
            aw_v_r      <= 1'b0;
            w_v_r       <= 1'b0;
            ar_v_r      <= 1'b0;
            drain_b_r   <= 1'b0;
            drain_r_r   <= 1'b0;
            timer_r     <= '0;
            resp_data_r <= '0;
            resp_code_r <= '0;
        end else begin
            state_r     <= state_n;
            // Registered so ready stays low through reset and is never combinational
            req_ready_r <= (state_n == e_ready);

            if (accept) begin
                addr_r  <= req_axil_addr;
                wdata_r <= axil_data_width_p'(dmi_req_data_i);
            end

            if (accept && dmi_req_op_i == op_write_lp) begin
                aw_v_r <= 1'b1;
                w_v_r  <= 1'b1;
            end else begin
                if (m_axil_awready_i) aw_v_r <= 1'b0;
                if (m_axil_wready_i)  w_v_r  <= 1'b0;
            end

            if (accept && dmi_req_op_i == op_read_lp) begin
                ar_v_r <= 1'b1;
            end else if (m_axil_arready_i) begin
                ar_v_r <= 1'b0;
            end

            if (accept) begin
                timer_r <= '0;
            end else if (in_timed) begin
                timer_r <= timer_r + timer_width_lp'(1);
            end

            if (set_drain_b) begin
                drain_b_r <= 1'b1;
            end else if (m_axil_bvalid_i) begin
                drain_b_r <= 1'b0;
            end

            if (set_drain_r) begin
                drain_r_r <= 1'b1;
            end else if (m_axil_rvalid_i) begin
                drain_r_r <= 1'b0;
            end

            if (load_resp) begin
                resp_data_r <= resp_data_n;
                resp_code_r <= resp_code_n;
            end
        end
    end

    assign dmi_req_ready_o  = req_ready_r;
    assign dmi_resp_v_o     = (state_r == e_resp);
    assign dmi_resp_data_o  = resp_data_r;
    assign dmi_resp_resp_o  = resp_code_r;

    assign m_axil_awaddr_o  = addr_r;
    assign m_axil_awprot_o  = 3'b000;
    assign m_axil_awvalid_o = aw_v_r;
    assign m_axil_wdata_o   = wdata_r;
    assign m_axil_wstrb_o   = {(axil_data_width_p/8){1'b1}};
    assign m_axil_wvalid_o  = w_v_r;
    assign m_axil_bready_o  = (state_r == e_wait_b) | drain_b_r;
    assign m_axil_araddr_o  = addr_r;
    assign m_axil_arprot_o  = 3'b000;
    assign m_axil_arvalid_o = ar_v_r;
    assign m_axil_rready_o  = (state_r == e_wait_r) | drain_r_r;

endmodule
